// File: rtl/md_unit_pkg.sv
// rtl/md_unit_pkg.sv - shared op encodings, default latencies and FSM state type for md_unit
package md_unit_pkg;

  localparam logic [2:0] OP_MULT  = 3'b001;
  localparam logic [2:0] OP_MULTU = 3'b010;
  localparam logic [2:0] OP_DIV   = 3'b011;
  localparam logic [2:0] OP_DIVU  = 3'b100;
  localparam logic [2:0] OP_MTHI  = 3'b101;
  localparam logic [2:0] OP_MTLO  = 3'b110;

  localparam int MUL_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF = 10;
  localparam int CNT_W          = 16;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MUL,
    ST_DIV
  } md_state_e;

  function automatic logic is_div(input logic [2:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/md_compute.sv
// rtl/md_compute.sv - combinational multiply/divide datapath producing {HI,LO} and a divide-by-zero flag
module md_compute
  import md_unit_pkg::*;
(
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic [2:0]  op_i,
  output logic [63:0] result_o,
  output logic        div_by_zero_o
);

  logic        sgn;
  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [31:0] divisor;
  logic [31:0] q_mag;
  logic [31:0] r_mag;
  logic [31:0] q;
  logic [31:0] r;

  // Signed divide runs on magnitudes so 0x80000000 / -1 wraps to 0x80000000 cleanly.
  always_comb begin
    sgn           = (op_i == OP_MULT) || (op_i == OP_DIV);
    prod_u        = {32'b0, a_i} * {32'b0, b_i};
    prod_s        = $signed({{32{a_i[31]}}, a_i}) * $signed({{32{b_i[31]}}, b_i});
    a_mag         = (sgn && a_i[31]) ? -a_i : a_i;
    b_mag         = (sgn && b_i[31]) ? -b_i : b_i;
    div_by_zero_o = (b_i == 32'b0);
    divisor       = div_by_zero_o ? 32'd1 : b_mag;
    q_mag         = a_mag / divisor;
    r_mag         = a_mag % divisor;
    q             = (sgn && (a_i[31] ^ b_i[31])) ? -q_mag : q_mag;
    r             = (sgn && a_i[31]) ? -r_mag : r_mag;
    result_o      = is_div(op_i) ? {r, q} : (sgn ? prod_s : prod_u);
  end

endmodule

// File: rtl/md_unit.sv
// rtl/md_unit.sv - multi-cycle HI/LO multiply/divide unit with fixed busy latency
module md_unit
  import md_unit_pkg::*;
#(
  parameter int MUL_CYCLES = MUL_CYCLES_DEF,
  parameter int DIV_CYCLES = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  md_state_e        state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [31:0]      a_q;
  logic [31:0]      b_q;
  logic [2:0]       op_q;
  logic [31:0]      hi_q;
  logic [31:0]      lo_q;
  logic             busy_q;
  logic [63:0]      result;
  logic             div_by_zero;

  md_compute u_compute (
    .a_i          (a_q),
    .b_i          (b_q),
    .op_i         (op_q),
    .result_o     (result),
    .div_by_zero_o(div_by_zero)
  );

  assign cnt_d = cnt_q - CNT_W'(1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            case (op)
              OP_MULT, OP_MULTU: begin
                state_q <= ST_MUL;
                cnt_q   <= CNT_W'(MUL_CYCLES);
                busy_q  <= 1'b1;
                a_q     <= A;
                b_q     <= B;
                op_q    <= op;
              end
              OP_DIV, OP_DIVU: begin
                state_q <= ST_DIV;
                cnt_q   <= CNT_W'(DIV_CYCLES);
                busy_q  <= 1'b1;
                a_q     <= A;
                b_q     <= B;
                op_q    <= op;
              end
              OP_MTHI: hi_q <= A;
              OP_MTLO: lo_q <= A;
              default: ;
            endcase
          end
        end
        ST_MUL, ST_DIV: begin
          // Starts are not examined here, so anything issued while busy is dropped.
          cnt_q <= cnt_d;
          if (cnt_d == '0) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            if (!(state_q == ST_DIV && div_by_zero)) begin
              hi_q <= result[63:32];
              lo_q <= result[31:0];
            end
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign HI   = hi_q;
  assign LO   = lo_q;

endmodule

// File: tb/tb_md_unit.sv
// tb/tb_md_unit.sv - directed self-checking bench for md_unit
module tb_md_unit;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic [2:0]  op;
  logic [31:0] A;
  logic [31:0] B;
  logic        busy;
  logic [31:0] HI;
  logic [31:0] LO;

  int checks = 0;
  int errors = 0;

  md_unit #(.MUL_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .start  (start),
    .op     (op),
    .A      (A),
    .B      (B),
    .busy   (busy),
    .HI     (HI),
    .LO     (LO)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issues one op, scrambles operands after acceptance, counts busy cycles
  // and notes whether HI/LO moved while busy.
  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        output int cycles, output bit held);
    logic [31:0] h0;
    logic [31:0] l0;
    h0 = HI;
    l0 = LO;
    start = 1'b1;
    op = o;
    A = a;
    B = b;
    tick();
    start = 1'b0;
    op = 3'b000;
    A = $urandom;
    B = $urandom;
    cycles = 0;
    held = 1'b1;
    while (busy && cycles < 200) begin
      cycles++;
      if (HI !== h0 || LO !== l0) held = 1'b0;
      tick();
    end
  endtask

  task automatic test_reset();
    start = 1'b0;
    op = 3'b000;
    A = '0;
    B = '0;
    reset_n = 1'b0;
    #23;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b want 0", busy); end
    checks++; if (HI !== 32'h0) begin errors++; $display("FAIL reset_hi got %h want 00000000", HI); end
    checks++; if (LO !== 32'h0) begin errors++; $display("FAIL reset_lo got %h want 00000000", LO); end
    reset_n = 1'b1;
    #1;
  endtask

  task automatic test_mult();
    int cyc;
    bit held;
    run_op(3'b001, 32'hFFFF_FFFE, 32'd3, cyc, held);
    checks++; if (cyc !== 5) begin errors++; $display("FAIL mult_cycles got %0d want 5", cyc); end
    checks++; if (held !== 1'b1) begin errors++; $display("FAIL mult_hold got %0b want 1", held); end
    checks++; if (HI !== 32'hFFFF_FFFF) begin errors++; $display("FAIL mult_hi got %h want ffffffff", HI); end
    checks++; if (LO !== 32'hFFFF_FFFA) begin errors++; $display("FAIL mult_lo got %h want fffffffa", LO); end
  endtask

  task automatic test_multu();
    int cyc;
    bit held;
    run_op(3'b010, 32'hFFFF_FFFF, 32'd2, cyc, held);
    checks++; if (cyc !== 5) begin errors++; $display("FAIL multu_cycles got %0d want 5", cyc); end
    checks++; if (held !== 1'b1) begin errors++; $display("FAIL multu_hold got %0b want 1", held); end
    checks++; if (HI !== 32'h0000_0001) begin errors++; $display("FAIL multu_hi got %h want 00000001", HI); end
    checks++; if (LO !== 32'hFFFF_FFFE) begin errors++; $display("FAIL multu_lo got %h want fffffffe", LO); end
  endtask

  task automatic test_div();
    int cyc;
    bit held;
    run_op(3'b011, 32'hFFFF_FFF9, 32'd2, cyc, held);
    checks++; if (cyc !== 10) begin errors++; $display("FAIL div_cycles got %0d want 10", cyc); end
    checks++; if (held !== 1'b1) begin errors++; $display("FAIL div_hold got %0b want 1", held); end
    checks++; if (LO !== 32'hFFFF_FFFD) begin errors++; $display("FAIL div_lo got %h want fffffffd", LO); end
    checks++; if (HI !== 32'hFFFF_FFFF) begin errors++; $display("FAIL div_hi got %h want ffffffff", HI); end
    run_op(3'b011, 32'h8000_0000, 32'hFFFF_FFFF, cyc, held);
    checks++; if (LO !== 32'h8000_0000) begin errors++; $display("FAIL divovf_lo got %h want 80000000", LO); end
    checks++; if (HI !== 32'h0000_0000) begin errors++; $display("FAIL divovf_hi got %h want 00000000", HI); end
    run_op(3'b100, 32'hFFFF_FFF9, 32'd2, cyc, held);
    checks++; if (LO !== 32'h7FFF_FFFC) begin errors++; $display("FAIL divu_lo got %h want 7ffffffc", LO); end
    checks++; if (HI !== 32'h0000_0001) begin errors++; $display("FAIL divu_hi got %h want 00000001", HI); end
  endtask

  task automatic test_mthi_div0();
    int cyc;
    bit held;
    start = 1'b1;
    op = 3'b101;
    A = 32'h1234_5678;
    tick();
    start = 1'b0;
    op = 3'b000;
    checks++; if (HI !== 32'h1234_5678) begin errors++; $display("FAIL mthi_hi got %h want 12345678", HI); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mthi_busy got %0b want 0", busy); end
    checks++; if (LO !== 32'h7FFF_FFFC) begin errors++; $display("FAIL mthi_lo got %h want 7ffffffc", LO); end
    run_op(3'b100, 32'd5, 32'd0, cyc, held);
    checks++; if (cyc !== 10) begin errors++; $display("FAIL div0_cycles got %0d want 10", cyc); end
    checks++; if (HI !== 32'h1234_5678) begin errors++; $display("FAIL div0_hi got %h want 12345678", HI); end
    checks++; if (LO !== 32'h7FFF_FFFC) begin errors++; $display("FAIL div0_lo got %h want 7ffffffc", LO); end
  endtask

  task automatic test_busy_ignore();
    int cyc;
    start = 1'b1;
    op = 3'b001;
    A = 32'd7;
    B = 32'd6;
    tick();
    cyc = 1;
    start = 1'b0;
    op = 3'b000;
    tick();
    cyc++;
    start = 1'b1;
    op = 3'b110;
    A = 32'h0000_DEAD;
    B = 32'h0000_0100;
    tick();
    cyc++;
    start = 1'b0;
    op = 3'b000;
    while (busy && cyc < 200) begin
      tick();
      cyc++;
    end
    checks++; if (cyc !== 6) begin errors++; $display("FAIL ignore_cycles got %0d want 6", cyc); end
    checks++; if (LO !== 32'd42) begin errors++; $display("FAIL ignore_lo got %h want 0000002a", LO); end
    checks++; if (HI !== 32'd0) begin errors++; $display("FAIL ignore_hi got %h want 00000000", HI); end
  endtask

  task automatic test_undef_op();
    start = 1'b1;
    op = 3'b111;
    A = 32'hAAAA_5555;
    tick();
    op = 3'b000;
    tick();
    start = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL undef_busy got %0b want 0", busy); end
    checks++; if (LO !== 32'd42) begin errors++; $display("FAIL undef_lo got %h want 0000002a", LO); end
    checks++; if (HI !== 32'd0) begin errors++; $display("FAIL undef_hi got %h want 00000000", HI); end
  endtask

  task automatic test_reset_abort();
    start = 1'b1;
    op = 3'b101;
    A = 32'h0BAD_F00D;
    tick();
    op = 3'b011;
    A = 32'd100;
    B = 32'd7;
    tick();
    start = 1'b0;
    op = 3'b000;
    tick();
    tick();
    tick();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL abort_busy_pre got %0b want 1", busy); end
    #3;
    reset_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy got %0b want 0", busy); end
    checks++; if (HI !== 32'h0) begin errors++; $display("FAIL abort_hi got %h want 00000000", HI); end
    checks++; if (LO !== 32'h0) begin errors++; $display("FAIL abort_lo got %h want 00000000", LO); end
    #2;
    reset_n = 1'b1;
    repeat (12) tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy_post got %0b want 0", busy); end
    checks++; if (HI !== 32'h0) begin errors++; $display("FAIL abort_hi_post got %h want 00000000", HI); end
    checks++; if (LO !== 32'h0) begin errors++; $display("FAIL abort_lo_post got %h want 00000000", LO); end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_multu();
    test_div();
    test_mthi_div0();
    reset_n = 1'b0;
    #2;
    reset_n = 1'b1;
    test_busy_ignore();
    test_undef_op();
    test_reset_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
